fir_tap_sequencer: RTL and testbench

- Control block for the FIR filter; sequences the 512-entry coefficient ROM (35-bit words, 1-cycle registered read) and a 512-entry circular sample buffer RAM (also 1-cycle registered read).
- For each incoming audio sample it:
  - writes the sample into the ring buffer;
  - walks all taps, issuing matched coefficient and sample addresses;
  - drives the MAC enable, clear and last strobes;
  - pulses result-valid when the MAC output is final.
- Sits between the codec sample interface and the MAC datapath.

---
 rtl/fir_tap_sequencer_pkg.sv | 25 ++
 rtl/fir_tap_sequencer_if.sv | 45 ++++
 rtl/fir_tap_sequencer_pending.sv | 47 ++++
 rtl/fir_tap_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_tap_sequencer_pkg.sv
// fir_seq_pkg: shared constants for the FIR tap sequencer slice.
//   - default geometry (taps, address width, sample width, MAC latency)
//   - FSM state encodings, kept as plain logic constants
//   - drain_count(): cycles spent in DRAIN, including the res_valid cycle
package fir_seq_pkg;

  localparam int NTAPS_DEF   = 512;
  localparam int AW_DEF      = 9;
  localparam int DW_DEF      = 24;
  localparam int MAC_LAT_DEF = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;

  // One cycle for the final registered ROM/RAM read, then the MAC pipeline.
  function automatic int drain_count(input int mac_lat);
    return mac_lat + 1;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: bundle between the codec sample side, the
// coefficient ROM / sample ring buffer and the MAC datapath.
//   master : the sequencer (consumes smp_valid/smp_din, drives the rest)
//   slave  : the surrounding datapath / codec side
// Signals:
//   smp_valid, smp_din          new audio sample strobe and data
//   buf_we, buf_waddr, buf_wdata ring buffer write port
//   buf_raddr, coef_addr        matched read addresses
//   mac_en, mac_clr, mac_last   MAC control strobes
//   res_valid                   MAC output is a finished filter result
//   busy, overrun               status
interface fir_tap_sequencer_if
  import fir_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          smp_valid;
  logic [DW-1:0] smp_din;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [AW-1:0] coef_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          res_valid;
  logic          busy;
  logic          overrun;

  modport master (
    input  smp_valid, smp_din,
    output buf_we, buf_waddr, buf_wdata, buf_raddr, coef_addr,
    output mac_en, mac_clr, mac_last, res_valid, busy, overrun
  );

  modport slave (
    output smp_valid, smp_din,
    input  buf_we, buf_waddr, buf_wdata, buf_raddr, coef_addr,
    input  mac_en, mac_clr, mac_last, res_valid, busy, overrun
  );

endinterface

// File: rtl/fir_tap_sequencer_pending.sv
// fir_seq_pending: one-entry holding register for samples that arrive while
// the sequencer is busy.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         a sample wants to be held
//   consume      the sequencer takes the held sample this cycle
//   din          sample to hold
//   full         a sample is held
//   dout         the held sample
//   overrun      sticky: a sample was dropped because the register was full
module fir_seq_pending
  import fir_seq_pkg::*;
#(
  parameter int DW = DW_DEF
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          consume,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic [DW-1:0] dout,
  output logic          overrun
);

  // A load in the same cycle as a consume refills the slot, so it never
  // counts as an overrun; only a load into an occupied, unconsumed slot is
  // dropped, and the held sample is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load && (consume || !full)) begin
        dout <= din;
        full <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end else if (load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: control FSM for the FIR filter.
// Zero-fills the sample ring buffer after reset, then for every sample
// writes it into the ring, walks all taps with matched coefficient and
// sample addresses, drives the MAC strobes one cycle behind the reads and
// pulses res_valid once the MAC pipeline has settled.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          fir_tap_sequencer_if.master (sample in, buffer/ROM
//                addresses, MAC strobes, status)
// All outputs are registered.
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
)
(
  input  logic                clk,
  input  logic                rst_n,
  fir_tap_sequencer_if.master bus
);

  localparam int KW        = AW + 1;
  localparam int DEPTH     = 2 ** AW;
  localparam int DRAIN_CNT = drain_count(MAC_LAT);
  localparam int DCW       = $clog2(DRAIN_CNT);

  localparam logic [KW-1:0]  K_LAST   = KW'(NTAPS - 1);
  localparam logic [KW-1:0]  INIT_END = KW'(DEPTH);
  localparam logic [DCW-1:0] D_LAST   = DCW'(DRAIN_CNT - 1);

  state_t         state, state_nx;
  logic [KW-1:0]  k, k_nx;
  logic [KW-1:0]  init_cnt, init_nx;
  logic [DCW-1:0] dcnt, dcnt_nx;
  logic [AW-1:0]  base, base_nx;
  logic [AW-1:0]  wr_ptr, wr_ptr_nx;

  logic           we_nx;
  logic [AW-1:0]  waddr_nx;
  logic [DW-1:0]  wdata_nx;
  logic [AW-1:0]  coef_nx;
  logic [AW-1:0]  raddr_nx;

  logic           launch;
  logic [DW-1:0]  launch_data;
  logic           direct_cap;
  logic           pend_consume;
  logic           pend_load;
  logic           pend_full;
  logic [DW-1:0]  pend_data;
  logic           pend_overrun;

  // Any sample not taken straight from IDLE goes to the holding register.
  assign pend_load = bus.smp_valid && !direct_cap;

  fir_seq_pending #(.DW(DW)) u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pend_load),
    .consume (pend_consume),
    .din     (bus.smp_din),
    .full    (pend_full),
    .dout    (pend_data),
    .overrun (pend_overrun)
  );

  assign bus.overrun = pend_overrun;

  // Next-state logic. The *_nx output values describe the cycle after the
  // coming edge, which is what lets every output be a plain register while
  // still lining up with the state it belongs to. A held sample always wins
  // over IDLE so samples collected during INIT or a run are never stranded.
  always_comb begin
    state_nx     = state;
    k_nx         = k;
    init_nx      = init_cnt;
    dcnt_nx      = dcnt;
    base_nx      = base;
    wr_ptr_nx    = wr_ptr;
    we_nx        = 1'b0;
    waddr_nx     = bus.buf_waddr;
    wdata_nx     = bus.buf_wdata;
    coef_nx      = bus.coef_addr;
    raddr_nx     = bus.buf_raddr;
    launch       = 1'b0;
    launch_data  = pend_data;
    direct_cap   = 1'b0;
    pend_consume = 1'b0;

    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_END) begin
          if (pend_full) begin
            launch       = 1'b1;
            pend_consume = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          we_nx    = 1'b1;
          waddr_nx = init_cnt[AW-1:0];
          wdata_nx = '0;
          init_nx  = init_cnt + KW'(1);
        end
      end
      ST_IDLE: begin
        if (pend_full) begin
          launch       = 1'b1;
          pend_consume = 1'b1;
        end else if (bus.smp_valid) begin
          launch      = 1'b1;
          launch_data = bus.smp_din;
          direct_cap  = 1'b1;
        end
      end
      ST_WRITE: begin
        state_nx  = ST_RUN;
        base_nx   = wr_ptr;
        wr_ptr_nx = wr_ptr + AW'(1);
        k_nx      = '0;
        coef_nx   = '0;
        raddr_nx  = wr_ptr;
      end
      ST_RUN: begin
        if (k == K_LAST) begin
          state_nx = ST_DRAIN;
          dcnt_nx  = '0;
        end else begin
          k_nx     = k + KW'(1);
          coef_nx  = k_nx[AW-1:0];
          raddr_nx = base - k_nx[AW-1:0];
        end
      end
      ST_DRAIN: begin
        if (dcnt == D_LAST) begin
          if (pend_full) begin
            launch       = 1'b1;
            pend_consume = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          dcnt_nx = dcnt + DCW'(1);
        end
      end
      default: state_nx = ST_INIT;
    endcase

    if (launch) begin
      state_nx = ST_WRITE;
      we_nx    = 1'b1;
      waddr_nx = wr_ptr;
      wdata_nx = launch_data;
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      k        <= '0;
      init_cnt <= '0;
      dcnt     <= '0;
      base     <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nx;
      k        <= k_nx;
      init_cnt <= init_nx;
      dcnt     <= dcnt_nx;
      base     <= base_nx;
      wr_ptr   <= wr_ptr_nx;
    end
  end

  // Output registers. The MAC strobes are taken from the current RUN state
  // rather than the next one, which delays them by exactly the one-cycle
  // read latency of the ROM and the ring buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.buf_we    <= 1'b0;
      bus.buf_waddr <= '0;
      bus.buf_wdata <= '0;
      bus.buf_raddr <= '0;
      bus.coef_addr <= '0;
      bus.mac_en    <= 1'b0;
      bus.mac_clr   <= 1'b0;
      bus.mac_last  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.buf_we    <= we_nx;
      bus.buf_waddr <= waddr_nx;
      bus.buf_wdata <= wdata_nx;
      bus.buf_raddr <= raddr_nx;
      bus.coef_addr <= coef_nx;
      bus.mac_en    <= (state == ST_RUN);
      bus.mac_clr   <= (state == ST_RUN) && (k == '0);
      bus.mac_last  <= (state == ST_RUN) && (k == K_LAST);
      bus.res_valid <= (state_nx == ST_DRAIN) && (dcnt_nx == D_LAST);
      bus.busy      <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: self-checking bench for fir_tap_sequencer with
// NTAPS=8, AW=4, DW=24, MAC_LAT=2. Models the coefficient ROM, the ring
// buffer RAM and a two-stage MAC around the DUT; a reference FIR computed
// from the bench's own sample history is queued when each sample is driven
// and compared when res_valid fires.
module tb_fir_tap_sequencer;

  localparam int NT    = 8;
  localparam int AWT   = 4;
  localparam int DWT   = 24;
  localparam int ML    = 2;
  localparam int RES_T = NT + ML + 2;

  typedef struct {
    logic [63:0] val;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wp = 0;

  exp_t           sb[$];
  logic [DWT-1:0] hist[$];

  fir_tap_sequencer_if #(.AW(AWT), .DW(DWT)) bus ();

  fir_tap_sequencer #(.NTAPS(NT), .AW(AWT), .DW(DWT), .MAC_LAT(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [34:0] coef_of(input int a);
    return 35'(a * 1234567 + 89);
  endfunction

  // Reference FIR over the accepted samples; older taps read zero-fill.
  function automatic logic [63:0] fir_ref();
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < NT; k++) begin
      int idx;
      idx = hist.size() - 1 - k;
      if (idx >= 0) s += 64'(coef_of(k)) * 64'(hist[idx]);
    end
    return s;
  endfunction

  // Datapath models: registered ROM/RAM reads and a two-stage MAC.
  logic [DWT-1:0] ram [16];
  logic [34:0]    rom_q;
  logic [DWT-1:0] ram_q;
  logic [63:0]    p1, acc;
  logic           v1, c1;

  always @(posedge clk) begin
    rom_q <= coef_of(int'(bus.coef_addr));
    ram_q <= ram[bus.buf_raddr];
    if (bus.buf_we) ram[bus.buf_waddr] <= bus.buf_wdata;
    p1 <= 64'(rom_q) * 64'(ram_q);
    v1 <= bus.mac_en;
    c1 <= bus.mac_clr;
    if (v1) acc <= c1 ? p1 : acc + p1;
  end

  // Scoreboard side: every res_valid pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_res_valid cycle %0d: res_valid=1, expected 0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (acc !== e.val || cyc != e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                   acc, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic push_expected(input logic [DWT-1:0] din, input int at_cyc);
    exp_t e;
    hist.push_back(din);
    e.val = fir_ref();
    e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    logic [42:0] v;
    v = {bus.buf_we, bus.buf_waddr, bus.buf_wdata, bus.buf_raddr, bus.coef_addr,
         bus.mac_en, bus.mac_clr, bus.mac_last, bus.res_valid, bus.busy, bus.overrun};
    tests_run++;
    if (v !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s: outputs %h, expected 0", name, v);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.smp_valid = 1'b0;
    bus.smp_din = '0;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(negedge clk);
    sb.delete();
    hist.delete();
    wp = 0;
    rst_n = 1'b1;
  endtask

  // Follows a zero-fill to IDLE with a cycle bound and checks it.
  task automatic wait_init();
    int nwe;
    bit bad;
    bit done;
    nwe = 0; bad = 0; done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.buf_we) begin
        if (bus.buf_waddr !== 4'(nwe) || bus.buf_wdata !== '0) bad = 1;
        nwe++;
      end
      if (!bus.busy) begin
        done = 1;
        break;
      end
    end
    tests_run++;
    if (!done || bad || nwe != 16) begin
      tests_failed++;
      $display("[TB] FAIL init_fill: writes=%0d bad_addr=%0d idle=%0d, expected 16/0/1", nwe, bad, done);
    end
  endtask

  // Drives one sample from IDLE and checks the full per-cycle sequence.
  task automatic run_one(input logic [DWT-1:0] din, input logic [3:0] base);
    int c0;
    c0 = cyc;
    bus.smp_valid = 1'b1;
    bus.smp_din = din;
    push_expected(din, c0 + RES_T);
    for (int t = 1; t <= RES_T + 1; t++) begin
      logic [3:0] e_str;
      logic [3:0] o_str;
      @(negedge clk);
      bus.smp_valid = 1'b0;
      e_str = {t == 1, t >= 3 && t <= NT + 2, t == 3, t == NT + 2};
      o_str = {bus.buf_we, bus.mac_en, bus.mac_clr, bus.mac_last};
      tests_run++;
      if (o_str !== e_str) begin
        tests_failed++;
        $display("[TB] FAIL strobes t=%0d: we/en/clr/last=%b, expected %b", t, o_str, e_str);
      end
      if (t == 1) begin
        tests_run++;
        if (bus.buf_waddr !== base || bus.buf_wdata !== din) begin
          tests_failed++;
          $display("[TB] FAIL write_port: waddr=%0d wdata=%h, expected %0d %h",
                   bus.buf_waddr, bus.buf_wdata, base, din);
        end
      end
      if (t >= 2 && t <= NT + 1) begin
        logic [3:0] ek;
        ek = 4'(t - 2);
        tests_run++;
        if (bus.coef_addr !== ek || bus.buf_raddr !== 4'(base - ek)) begin
          tests_failed++;
          $display("[TB] FAIL tap_addr t=%0d: coef=%0d raddr=%0d, expected %0d %0d",
                   t, bus.coef_addr, bus.buf_raddr, ek, 4'(base - ek));
        end
      end
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_result: busy=%b, expected 0", bus.busy);
    end
    wp = wp + 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.buf_we !== 1'b1 || bus.buf_waddr !== 4'(i) || bus.buf_wdata !== '0 || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL init_word %0d: we=%b waddr=%0d wdata=%h busy=%b, expected 1 %0d 0 1",
                 i, bus.buf_we, bus.buf_waddr, bus.buf_wdata, bus.busy, i);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.buf_we !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL init_done: we=%b busy=%b, expected 0 0", bus.buf_we, bus.busy);
    end
  endtask

  task automatic test_single();
    run_one(24'h000123, 4'(wp));
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [DWT-1:0] a, b;
    bit idle;
    a = 24'h0A0B0C; b = 24'h123456;
    c0 = cyc;
    idle = 0;
    bus.smp_valid = 1'b1;
    bus.smp_din = a;
    push_expected(a, c0 + RES_T);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      bus.smp_valid = 1'b0;
      if (t == 4) begin
        bus.smp_valid = 1'b1;
        bus.smp_din = b;
        push_expected(b, c0 + 2 * RES_T);
      end
      if (t == RES_T + 1) begin
        tests_run++;
        if (bus.buf_we !== 1'b1 || bus.buf_waddr !== 4'(wp + 1) || bus.buf_wdata !== b) begin
          tests_failed++;
          $display("[TB] FAIL b2b_write: we=%b waddr=%0d wdata=%h, expected 1 %0d %h",
                   bus.buf_we, bus.buf_waddr, bus.buf_wdata, 4'(wp + 1), b);
        end
      end
      if (t > 2 * RES_T && !bus.busy) begin
        idle = 1;
        break;
      end
    end
    tests_run++;
    if (!idle || sb.size() != 0 || bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_end: idle=%0d pending_results=%0d overrun=%b, expected 1 0 0",
               idle, sb.size(), bus.overrun);
    end
    wp = wp + 2;
  endtask

  task automatic test_overrun();
    int c0;
    bit idle;
    c0 = cyc;
    idle = 0;
    bus.smp_valid = 1'b1;
    bus.smp_din = 24'h00BEEF;
    push_expected(24'h00BEEF, c0 + RES_T);
    for (int t = 1; t <= 45; t++) begin
      @(negedge clk);
      bus.smp_valid = 1'b0;
      if (t == 3) begin
        bus.smp_valid = 1'b1;
        bus.smp_din = 24'h000777;
        push_expected(24'h000777, c0 + 2 * RES_T);
      end
      if (t == 5) begin
        tests_run++;
        if (bus.overrun !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL overrun_early: overrun=%b, expected 0", bus.overrun);
        end
        bus.smp_valid = 1'b1;
        bus.smp_din = 24'hDEAD00;
      end
      if (t == 6) begin
        tests_run++;
        if (bus.overrun !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL overrun_set: overrun=%b, expected 1", bus.overrun);
        end
      end
      if (t > 2 * RES_T + 5 && !bus.busy) begin
        idle = 1;
        break;
      end
    end
    tests_run++;
    if (!idle || sb.size() != 0 || bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overrun_end: idle=%0d pending_results=%0d overrun=%b, expected 1 0 1",
               idle, sb.size(), bus.overrun);
    end
    wp = wp + 2;
  endtask

  task automatic test_abort();
    bus.smp_valid = 1'b1;
    bus.smp_din = 24'h55AA55;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      bus.smp_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    sb.delete();
    hist.delete();
    wp = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    run_one(24'h000321, 4'd0);
  endtask

  task automatic test_wrap();
    do_reset();
    wait_init();
    for (int i = 0; i < 17; i++) begin
      run_one(24'($urandom), 4'(i));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.smp_valid = 1'b0;
    bus.smp_din = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_wrap();
    repeat (4) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL missing_results: %0d outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
